wb_fifo_device: RTL and testbench

- Wishbone B4 classic single-transfer device. A write cycle pushes dat_i into an internal FIFO; a read cycle pops the head onto dat_o.
- The bus has no address. The device attaches to the device side of the team's Wishbone classic interface and satisfies its protocol properties: every request gets exactly one response, registered one clock after the request.
- Sideband status outputs expose the FIFO level.

---
 rtl/wb_fifo_device.sv | 130 +++++++++++++
 tb/tb_wb_fifo_device.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_fifo_device.sv
// Wishbone B4 classic single-transfer FIFO device.
// Writes push dat_i, reads pop onto dat_o, one registered response each.
module wb_fifo_device #(
  parameter int DAT_WIDTH = 8,
  parameter int DEPTH     = 16,
  parameter int STRICT    = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cyc_i,
  input  logic                       stb_i,
  input  logic                       we_i,
  input  logic [DAT_WIDTH-1:0]       dat_i,
  output logic                       ack_o,
  output logic                       err_o,
  output logic                       rty_o,
  output logic [DAT_WIDTH-1:0]       dat_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 rty_q, rty_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 push;

  logic [DAT_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rty_d    = 1'b0;
    dat_d    = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          state_d = RESP;
          if (we_i) begin
            if (!full_q) begin
              push     = 1'b1;
              ack_d    = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              level_d  = level_q + 1'b1;
            end else begin
              err_d = (STRICT != 0);
              rty_d = (STRICT == 0);
            end
          end else begin
            if (!empty_q) begin
              ack_d    = 1'b1;
              dat_d    = mem[rd_ptr_q];
              rd_ptr_d = rd_ptr_q + 1'b1;
              level_d  = level_q - 1'b1;
            end else begin
              err_d = (STRICT != 0);
              rty_d = (STRICT == 0);
            end
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rty_q    <= 1'b0;
      dat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rty_q    <= rty_d;
      dat_q    <= dat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is never reset; gate writes so an aborted request leaves it alone.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr_q] <= dat_i;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rty_o   = rty_q;
  assign dat_o   = dat_q;
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: tb/tb_wb_fifo_device.sv
// Scoreboard bench for wb_fifo_device: stimulus queues expected
// responses, a negedge monitor pops and compares each bus response.
module tb_wb_fifo_device;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int STRICT = 0;
  localparam logic [2:0] R_ACK  = 3'b100;
  localparam logic [2:0] R_FAIL = (STRICT != 0) ? 3'b010 : 3'b001;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cyc_i, stb_i, we_i;
  logic [DW-1:0] dat_i;
  logic          ack_o, err_o, rty_o;
  logic [DW-1:0] dat_o;
  logic [4:0]    level_o;
  logic          full_o, empty_o;

  typedef struct {
    logic [2:0]    resp;
    logic [DW-1:0] dat;
    logic [4:0]    lvl;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  wb_fifo_device #(.DAT_WIDTH(DW), .DEPTH(DEPTH), .STRICT(STRICT)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .cyc_i   (cyc_i),
    .stb_i   (stb_i),
    .we_i    (we_i),
    .dat_i   (dat_i),
    .ack_o   (ack_o),
    .err_o   (err_o),
    .rty_o   (rty_o),
    .dat_o   (dat_o),
    .level_o (level_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response on the bus must match the oldest expectation.
  always @(negedge clk_i) begin
    if (ack_o || err_o || rty_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_resp: got %b expected none",
                 {ack_o, err_o, rty_o});
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_kind", {29'd0, ack_o, err_o, rty_o}, {29'd0, e.resp});
        chk("resp_dat", {24'd0, dat_o}, {24'd0, e.dat});
        chk("resp_level", {27'd0, level_o}, {27'd0, e.lvl});
      end
    end
  end

  task automatic do_req(input logic we, input logic [DW-1:0] d,
                        input logic [2:0] r, input logic [DW-1:0] ed,
                        input logic [4:0] el);
    exp_t e;
    e.resp = r;
    e.dat  = ed;
    e.lvl  = el;
    sb.push_back(e);
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = we;
    dat_i = d;
    @(negedge clk_i);
    chk("resp_seen", {31'd0, ack_o | err_o | rty_o}, 32'd1);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    dat_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("rst_resp", {29'd0, ack_o, err_o, rty_o}, 32'd0);
    chk("rst_level", {27'd0, level_o}, 32'd0);
    chk("rst_empty", {31'd0, empty_o}, 32'd1);
    chk("rst_full", {31'd0, full_o}, 32'd0);
    chk("rst_dat", {24'd0, dat_o}, 32'd0);

    // single write then read
    do_req(1'b1, 8'hA5, R_ACK, 8'h00, 5'd1);
    chk("wr1_empty", {31'd0, empty_o}, 32'd0);
    do_req(1'b0, 8'h00, R_ACK, 8'hA5, 5'd0);
    chk("rd1_dat_clear", {24'd0, dat_o}, 32'd0);
    chk("rd1_empty", {31'd0, empty_o}, 32'd1);

    // fill with wrap of the write pointer, overflow
    for (int i = 0; i < 16; i++)
      do_req(1'b1, 8'(i), R_ACK, 8'h00, 5'(i + 1));
    chk("fill_full", {31'd0, full_o}, 32'd1);
    do_req(1'b1, 8'hEE, R_FAIL, 8'h00, 5'd16);
    chk("ovf_full", {31'd0, full_o}, 32'd1);

    // drain in order, then underflow
    for (int i = 0; i < 16; i++)
      do_req(1'b0, 8'h00, R_ACK, 8'(i), 5'(15 - i));
    do_req(1'b0, 8'h00, R_FAIL, 8'h00, 5'd0);
    chk("unf_empty", {31'd0, empty_o}, 32'd1);
    chk("unf_full", {31'd0, full_o}, 32'd0);

    // request held high: one transfer every 2 clocks
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.resp = R_ACK;
      e.dat  = 8'h00;
      e.lvl  = 5'(k + 1);
      sb.push_back(e);
    end
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      dat_i = 8'(8'h30 + k);
      @(negedge clk_i);
      chk("held_ack", {31'd0, ack_o}, {31'd0, 1'(k % 2)});
    end
    cyc_i = 1'b0;
    stb_i = 1'b0;
    @(negedge clk_i);
    chk("held_level", {27'd0, level_o}, 32'd4);
    do_req(1'b0, 8'h00, R_ACK, 8'h31, 5'd3);
    do_req(1'b0, 8'h00, R_ACK, 8'h33, 5'd2);
    do_req(1'b0, 8'h00, R_ACK, 8'h35, 5'd1);
    do_req(1'b0, 8'h00, R_ACK, 8'h37, 5'd0);

    // async reset aborts a pending write
    do_req(1'b1, 8'h77, R_ACK, 8'h00, 5'd1);
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = 1'b1;
    dat_i = 8'h88;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_level", {27'd0, level_o}, 32'd0);
    chk("arst_empty", {31'd0, empty_o}, 32'd1);
    @(negedge clk_i);
    chk("arst_noresp", {29'd0, ack_o, err_o, rty_o}, 32'd0);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_resp", {29'd0, ack_o, err_o, rty_o}, 32'd0);
    chk("post_rst_level", {27'd0, level_o}, 32'd0);
    do_req(1'b0, 8'h00, R_FAIL, 8'h00, 5'd0);

    repeat (2) @(negedge clk_i);
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
